// File: rtl/and_bist_pkg.sv
// and_bist_pkg: shared types and constants for the AND-datapath BIST sequencer.
//   state_e     - sequencer states, also exported on the top's debug port
//   NUM_FIXED   - number of fixed directed vectors
//   LFSR_SEED   - reload value of the optional pseudo-random operand source
//   LFSR_TAPS   - Galois feedback mask of that source
//   fixed_bits  - {a_bit, b_bit} of fixed vector idx at bit position pos
package and_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          NUM_FIXED = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Each fixed pattern is a per-bit rule, so any WIDTH is built by looping
  // over bit positions. Vector 3 is a = ...0101, b = ...1010 (bit 0 of a is 1).
  function automatic logic [1:0] fixed_bits(input logic [1:0] idx, input int unsigned pos);
    logic [1:0] r;
    case (idx)
      2'd0:    r = 2'b00;
      2'd1:    r = 2'b10;
      2'd2:    r = 2'b11;
      default: r = pos[0] ? 2'b01 : 2'b10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/and_bist_lfsr.sv
// and_bist_lfsr: 16-bit Galois LFSR (right shift, taps LFSR_TAPS).
//   clk   - clock
//   rst_n - synchronous active-low reset, loads LFSR_SEED
//   load  - reload LFSR_SEED (start of a run)
//   step  - advance one step
//   q     - current LFSR state
module and_bist_lfsr
  import and_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = LFSR_SEED;
    end else if (step) begin
      q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/and_bist.sv
// and_bist: built-in test sequencer for a WIDTH-bit bitwise AND unit.
// Drives operand pairs on a/b, waits SETTLE cycles, compares y with a & b,
// and reports a saturating mismatch count and the first failing index.
// Optional feature macro: AND_BIST_LFSR_EN appends LFSR_CNT pseudo-random
// vectors after the four fixed ones.
//   clk      - clock
//   rst_n    - synchronous active-low reset (aborts a run, no done)
//   start    - begin a run, sampled only in IDLE
//   a, b     - operands to the unit under test, held in IDLE
//   y        - result from the unit under test
//   busy     - high from the cycle after start through the DONE cycle
//   done     - one-cycle end-of-run pulse
//   pass     - err_cnt == 0
//   err_cnt  - saturating mismatch count
//   fail_idx - first failing vector index, 8'hFF if none
//   dbg_state- current sequencer state
module and_bist
  import and_bist_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SETTLE   = 1,
  parameter int ERR_W    = 4,
  parameter int LFSR_CNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       fail_idx,
  output state_e           dbg_state
);

`ifdef AND_BIST_LFSR_EN
  localparam int NUM_VEC = NUM_FIXED + LFSR_CNT;
`else
  // LFSR_CNT is kept in the parameter list so both builds share one interface.
  localparam int NUM_VEC = NUM_FIXED + 0 * LFSR_CNT;
`endif
  localparam logic [7:0] LAST_IDX  = 8'(NUM_VEC - 1);
  localparam logic [7:0] FIXED_LIM = 8'(NUM_FIXED);
  localparam int         WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [7:0]       vec_q, vec_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       fail_q, fail_d;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic             is_last;

  assign is_last = (vec_q == LAST_IDX);

`ifdef AND_BIST_LFSR_EN
  logic [15:0] lfsr_q;
  logic        lfsr_load;
  logic        lfsr_step;

  assign lfsr_load = (state_q == ST_IDLE) && start;
  // Step while leaving the CHECK that precedes a random vector, so each
  // random vector sees a freshly advanced LFSR in DRIVE.
  assign lfsr_step = (state_q == ST_CHECK) && !is_last && (vec_q >= FIXED_LIM - 8'd1);

  and_bist_lfsr u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (lfsr_q)
  );
`endif

  // Operand source for the current vector index.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    if (vec_q < FIXED_LIM) begin
      for (int i = 0; i < WIDTH; i++) begin
        {vec_a[i], vec_b[i]} = fixed_bits(vec_q[1:0], i);
      end
    end else begin
`ifdef AND_BIST_LFSR_EN
      for (int i = 0; i < WIDTH; i++) begin
        vec_a[i] = lfsr_q[i % 16];
        vec_b[i] = lfsr_q[(i + WIDTH) % 16];
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = '0;
          fail_d  = 8'hFF;
          vec_d   = 8'd0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        a_d     = vec_a;
        b_d     = vec_b;
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (y != (a_q & b_q)) begin
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
          end
          if (fail_q == 8'hFF) begin
            fail_d = vec_q;
          end
        end
        if (is_last) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 8'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 8'd0;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      fail_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = (err_q == '0);
  assign err_cnt   = err_q;
  assign fail_idx  = fail_q;
  assign dbg_state = state_q;

endmodule
